// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, encoder request kinds, immediate limits.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    KIND_LW   = 3'd0,
    KIND_SW   = 3'd1,
    KIND_R    = 3'd2,
    KIND_BEQ  = 3'd3,
    KIND_IALU = 3'd4,
    KIND_JAL  = 3'd5,
    KIND_BAD6 = 3'd6,
    KIND_BAD7 = 3'd7
  } kind_e;

  // Signed limits, sized to match the 21-bit request immediate.
  localparam logic signed [20:0] IMM12_MIN = -21'sd2048;
  localparam logic signed [20:0] IMM12_MAX = 21'sd2047;
  localparam logic signed [20:0] BR_MIN    = -21'sd4096;
  localparam logic signed [20:0] BR_MAX    = 21'sd4094;

  // funct3 values that select the shift-immediate layout in I-ALU.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational immediate scrambler: produces the immediate bit-fields of every
// instruction format and flags whether the request's immediate is encodable.
module imm_packer
  import rv32_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [20:0] imm,
  output logic [11:0] i_field,   // instr[31:20]
  output logic [11:0] s_field,   // {instr[31:25], instr[11:7]}
  output logic [11:0] b_field,   // {instr[31:25], instr[11:7]}
  output logic [19:0] j_field,   // instr[31:12]
  output logic        legal
);

  logic signed [20:0] simm;
  logic               shift_op;
  logic               in_imm12;
  logic               in_shamt;
  logic               in_branch;

  assign simm      = imm;
  assign shift_op  = is_shift_f3(funct3);
  assign in_imm12  = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
  assign in_shamt  = (imm[20:5] == 16'd0);
  assign in_branch = (simm >= BR_MIN) && (simm <= BR_MAX) && !imm[0];

  assign s_field = imm[11:0];
  assign b_field = {imm[12], imm[10:5], imm[4:1], imm[11]};
  assign j_field = {imm[20], imm[10:1], imm[11], imm[19:12]};

  // I-format field: shifts carry the funct7 pattern above a 5-bit shamt.
  always_comb begin
    i_field = imm[11:0];
    if (kind_e'(kind) == KIND_IALU && shift_op) begin
      i_field = {1'b0, f7b5, 5'b00000, imm[4:0]};
    end
  end

  // Per-kind legality of the immediate; unused kinds are never legal.
  always_comb begin
    legal = 1'b0;
    case (kind_e'(kind))
      KIND_LW, KIND_SW: legal = in_imm12;
      KIND_R:           legal = 1'b1;
      KIND_BEQ:         legal = in_branch;
      KIND_IALU:        legal = shift_op ? in_shamt : in_imm12;
      KIND_JAL:         legal = !imm[0];
      default:          legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts field-level requests, emits packed words
// with an auto-incrementing word address through a single output register.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int              ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [20:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic              wrapped
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  logic              out_valid_reg;
  logic [31:0]       out_instr_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              wrapped_reg;
  logic              err_reg;

  logic [31:0] instr_next;
  logic [11:0] i_field;
  logic [11:0] s_field;
  logic [11:0] b_field;
  logic [19:0] j_field;
  logic        legal;
  logic        accept;
  logic        transfer;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid_reg && out_ready;

  imm_packer u_imm_packer (
    .kind    (in_kind),
    .funct3  (in_funct3),
    .f7b5    (in_f7b5),
    .imm     (in_imm),
    .i_field (i_field),
    .s_field (s_field),
    .b_field (b_field),
    .j_field (j_field),
    .legal   (legal)
  );

  // Assemble the 32-bit word for the requested class.
  always_comb begin
    instr_next = 32'd0;
    case (kind_e'(in_kind))
      KIND_LW:   instr_next = {i_field, in_rs1, 3'b010, in_rd, OP_LOAD};
      KIND_SW:   instr_next = {s_field[11:5], in_rs2, in_rs1, 3'b010,
                               s_field[4:0], OP_STORE};
      KIND_R:    instr_next = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1,
                               in_funct3, in_rd, OP_R};
      KIND_BEQ:  instr_next = {b_field[11:5], in_rs2, in_rs1, 3'b000,
                               b_field[4:0], OP_BRANCH};
      KIND_IALU: instr_next = {i_field, in_rs1, in_funct3, in_rd, OP_I};
      KIND_JAL:  instr_next = {j_field, in_rd, OP_JAL};
      default:   instr_next = 32'd0;
    endcase
  end

  // Output register, address/count bookkeeping and the reject pulse.
  // A rejected request is consumed but never loads the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'd0;
      out_addr_reg  <= BASE_ADDR;
      count_reg     <= '0;
      wrapped_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else if (clr) begin
      out_valid_reg <= 1'b0;
      out_addr_reg  <= BASE_ADDR;
      count_reg     <= '0;
      wrapped_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= accept && !legal;
      if (transfer) begin
        out_addr_reg <= out_addr_reg + ADDR_ONE;
        if (&out_addr_reg) begin
          wrapped_reg <= 1'b1;
        end
        if (!(&count_reg)) begin
          count_reg <= count_reg + CNT_ONE;
        end
      end
      if (accept && legal) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= instr_next;
      end else if (transfer) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_addr  = out_addr_reg;
  assign count     = count_reg;
  assign wrapped   = wrapped_reg;
  assign err       = err_reg;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder; the producer-side counterpart of main_decoder.
- Accepts field-level instruction requests (class, registers, funct, immediate) over a valid/ready handshake.
- Packs each request into a 32-bit word for the six classes main_decoder implements: lw, sw, R-type, beq, I-ALU, jal.
- Emits each word with an auto-incrementing word address, for loading instruction memory from a test/boot controller.

Parameters:
ADDR_W, 6, width of emitted word address (instruction memory depth 2^ADDR_W)
BASE_ADDR, 0, address loaded on reset and on clr

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous: reload address to BASE_ADDR, zero count, clear wrapped
in_valid  in  1  request valid
in_ready  out  1  encoder can accept request
in_kind  in  3  0 lw, 1 sw, 2 R-type, 3 beq, 4 I-ALU, 5 jal, 6-7 illegal
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3 (R-type / I-ALU only)
in_f7b5  in  1  instr bit 30 (sub/sra/srai)
in_imm  in  21  signed immediate, byte offset for beq/jal
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  word address of out_instr
err  out  1  one-cycle pulse: request rejected
count  out  ADDR_W+1  words transferred since reset/clr
wrapped  out  1  sticky: address counter wrapped

Behaviour:
- Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, count=0, wrapped=0. in_ready=1 after reset.
- Single output register with pipeline-style ready: in_ready = !out_valid | out_ready.
- Accept when in_valid & in_ready. A legal request appears on out_instr/out_valid the next cycle (latency 1).
- Full throughput under continuous out_ready.
- out_valid and out_instr stay stable while out_valid & !out_ready.
- Transfer occurs on out_valid & out_ready:
  - out_addr increments by 1 modulo 2^ADDR_W and count increments.
  - Increment from all-ones sets wrapped; count saturates at 2^(ADDR_W+1)-1.
  - out_addr in the transfer cycle is the address of that word.
- Encodings:
  - lw: imm[11:0], rs1, 010, rd, 0000011. in_funct3 ignored.
  - sw: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
  - R-type: {0,f7b5,00000}, rs2, rs1, funct3, rd, 0110011.
  - beq: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011.
  - I-ALU: imm[11:0], rs1, funct3, rd, 0010011.
  - I-ALU shifts (funct3 001/101): bits[31:25] = {0,f7b5,00000}, bits[24:20] = imm[4:0].
  - jal: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
- Legality checks; failures are rejected:
  - lw/sw/I-ALU: imm in [-2048, 2047].
  - Shifts: imm in [0, 31].
  - beq: imm in [-4096, 4094], imm[0]=0.
  - jal: imm[0]=0; the full 21-bit range is legal.
  - in_kind 6 or 7: always rejected.
  - R-type: imm is ignored.
- Rejected request:
  - Is still consumed (handshake completes).
  - err pulses in the following cycle.
  - No word is emitted; out_addr and count are unchanged.
  - An existing held output is undisturbed.
- Simultaneous accept and transfer in the same cycle: the new word replaces the old, and the address advances once.
- clr has priority over a transfer in the same cycle. clr also drops a pending output (out_valid=0); an accept in the clr cycle is discarded.
- Async reset mid-transfer aborts immediately; no partial state survives.

Decomposition:
- Shared package rv32_pkg:
  - Opcode constants OP_LOAD 0000011, OP_STORE 0100011, OP_R 0110011, OP_BRANCH 1100011, OP_I 0010011, OP_JAL 1101111.
  - in_kind enum values.
  - Immediate range limits.
- main_decoder is updated to use rv32_pkg.
- One combinational sub-module imm_packer: inputs kind, funct3, imm; outputs the immediate bit-fields per format and a legal flag.
- The top holds the handshake register, address/count counters and error pulse.

Test Plan:
- addi x1,x0,5 (kind 4, funct3 000, imm 5) then lw x2,8(x1) with out_ready=1 -> 0x00500093 @addr0, then 0x0080A103 @addr1, one cycle after each accept; count=2.
- sw x2,4(x1) and sub x3,x1,x2 (f7b5=1) back-to-back -> 0x0020A223, 0x402081B3, consecutive addresses, no bubbles.
- beq x1,x2,-8 and jal x1,16 -> 0xFE208CE3, 0x010000EF.
- Backpressure: hold out_ready=0 for 5 cycles after one accept -> in_ready=0, out_instr stable, addr unchanged; release -> single transfer, addr +1.
- Errors: addi imm 2048, beq imm 3, kind 7 -> each err pulse one cycle, no out_valid, count unchanged.
- Issue 2^ADDR_W legal words -> out_addr wraps to 0, wrapped=1. Then clr -> out_addr=BASE_ADDR, count=0, wrapped=0. Assert rst_n low while out_valid=1 -> outputs at reset values immediately.
